// File: rtl/edge_sel_delay_line_pkg.sv
// Shared constants and helpers for the edge-selectable delay line.
// Edge-select encodings and a ceil-log2 helper used to size the fill counter.
package edge_sel_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_sel_delay_line_if.sv
// Data/control bundle between a producer and the edge-selectable delay line.
interface edge_sel_delay_line_if
  import edge_sel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();

  localparam int CW = clog2(DEPTH + 1);

  logic             en;
  logic             clr;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [CW-1:0]    fill_count;
  logic             full;

  modport master (
    output en, clr, d, d_valid,
    input  q, q_valid, fill_count, full
  );

  modport slave (
    input  en, clr, d, d_valid,
    output q, q_valid, fill_count, full
  );

endinterface

// File: rtl/edge_sel_delay_line_dff_r.sv
// One WIDTH-bit register on a build-time selected clock edge, with async reset,
// synchronous clear and enable (priority reset > clr > en > hold).
module edge_dff_r
  import edge_sel_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               NEG_EDGE  = EDGE_FALL,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  generate
    if (NEG_EDGE == EDGE_RISE) begin : g_rise
      always_ff @(posedge clk or posedge reset) begin
        if (reset)    r_q <= RESET_VAL;
        else if (clr) r_q <= RESET_VAL;
        else if (en)  r_q <= d;
      end
    end else begin : g_fall
      always_ff @(negedge clk or posedge reset) begin
        if (reset)    r_q <= RESET_VAL;
        else if (clr) r_q <= RESET_VAL;
        else if (en)  r_q <= d;
      end
    end
  endgenerate

  assign q = r_q;

endmodule

// File: rtl/edge_sel_delay_line.sv
// DEPTH-stage WIDTH-bit delay line with per-stage valids and a fill counter;
// all state captures on the edge chosen by NEG_EDGE.
module edge_sel_delay_line
  import edge_sel_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter int               NEG_EDGE  = EDGE_FALL,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  edge_sel_delay_line_if.slave  bus
);

  localparam int            CW      = clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] w_din   [DEPTH];
  logic [WIDTH-1:0] w_stage [DEPTH];
  logic             w_vin   [DEPTH];
  logic             w_vld   [DEPTH];
  logic [CW-1:0]    w_fill;
  logic [CW-1:0]    w_fill_nxt;

  assign w_din[0] = bus.d;
  assign w_vin[0] = bus.d_valid;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i > 0) begin : g_link
        assign w_din[i] = w_stage[i-1];
        assign w_vin[i] = w_vld[i-1];
      end

      edge_dff_r #(
        .WIDTH     (WIDTH),
        .NEG_EDGE  (NEG_EDGE),
        .RESET_VAL (RESET_VAL)
      ) u_data (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .clr   (bus.clr),
        .d     (w_din[i]),
        .q     (w_stage[i])
      );

      edge_dff_r #(
        .WIDTH     (1),
        .NEG_EDGE  (NEG_EDGE),
        .RESET_VAL (1'b0)
      ) u_vld (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .clr   (bus.clr),
        .d     (w_vin[i]),
        .q     (w_vld[i])
      );
    end
  endgenerate

  // A valid word in the last stage guarantees a non-zero count, and a full line
  // always has a valid last stage, so this sum never wraps.
  assign w_fill_nxt = w_fill + CW'(bus.d_valid) - CW'(w_vld[DEPTH-1]);

  edge_dff_r #(
    .WIDTH     (CW),
    .NEG_EDGE  (NEG_EDGE),
    .RESET_VAL ('0)
  ) u_fill (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .clr   (bus.clr),
    .d     (w_fill_nxt),
    .q     (w_fill)
  );

  assign bus.q          = w_stage[DEPTH-1];
  assign bus.q_valid    = w_vld[DEPTH-1];
  assign bus.fill_count = w_fill;
  assign bus.full       = (w_fill == DEPTH_C);

endmodule
